// File: rtl/fir_bank_pkg.sv
// Shared state encoding, width helpers and the output round/clamp stage
// used by the multi-bank FIR engine.
package fir_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_ROUND
    } fir_state_e;

    // Wide enough to hold any accumulator this engine will realistically be built with.
    localparam int RC_W = 128;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps) + 1;
    endfunction

    // Round half up, drop the fractional bits, restore mid-scale and saturate.
    function automatic logic [RC_W-1:0] round_clamp(
        input logic signed [RC_W-1:0] acc,
        input int                     frac_w,
        input int                     data_w,
        input logic                   dc_rm
    );
        logic signed [RC_W-1:0] one;
        logic signed [RC_W-1:0] half;
        logic signed [RC_W-1:0] y;
        logic signed [RC_W-1:0] max_v;
        one   = RC_W'(1);
        half  = '0;
        if (frac_w > 0) begin
            half = one << (frac_w - 1);
        end
        y = (acc + half) >>> frac_w;
        if (dc_rm) begin
            y = y + (one << (data_w - 1));
        end
        max_v = (one << data_w) - one;
        if (y[RC_W-1]) begin
            return '0;
        end else if (y > max_v) begin
            return max_v;
        end
        return y;
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample history with fill tracking, flush and a tap-offset read
// port; tap 0 is always the most recently written sample.
module fir_delay_line
    import fir_bank_pkg::*;
#(
    parameter int TAPS   = 23,
    parameter int DATA_W = 16,
    parameter int TAP_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flush,
    input  logic [TAP_W-1:0]  rd_tap,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam logic [TAP_W-1:0] LAST_PTR = TAP_W'(TAPS - 1);
    localparam logic [TAP_W:0]   FULL     = (TAP_W + 1)'(TAPS);
    localparam logic [TAP_W:0]   LAST_EXT = (TAP_W + 1)'(TAPS - 1);

    logic [DATA_W-1:0] mem_q [TAPS];
    logic [TAP_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [TAP_W:0]    fill_q, fill_d;
    logic [TAP_W-1:0]  wr_addr;
    logic [TAP_W-1:0]  rd_addr;
    logic [TAP_W:0]    rd_sum;

    // Flush is applied before a same-cycle write, so that sample lands at slot 0 with fill 1.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (flush) begin
            wr_ptr_d = '0;
            fill_d   = '0;
        end
        wr_addr = wr_ptr_d;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_d == LAST_PTR) ? '0 : wr_ptr_d + TAP_W'(1);
            if (fill_d != FULL) begin
                fill_d = fill_d + (TAP_W + 1)'(1);
            end
        end
    end

    always_comb begin
        rd_sum = {1'b0, wr_ptr_q} + LAST_EXT - {1'b0, rd_tap};
        if (rd_sum >= FULL) begin
            rd_sum = rd_sum - FULL;
        end
        rd_addr  = rd_sum[TAP_W-1:0];
        rd_data  = mem_q[rd_addr];
        rd_valid = ({1'b0, rd_tap} < fill_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/fir_filter_bank.sv
// Multi-bank FIR engine: one MAC per clock over the stored history against a
// runtime-loadable coefficient bank, followed by a single round/clamp cycle.
module fir_filter_bank
    import fir_bank_pkg::*;
#(
    parameter int                TAPS       = 23,
    parameter int                DATA_W     = 16,
    parameter int                COEF_W     = 32,
    parameter int                FRAC_W     = 31,
    parameter int                NBANKS     = 3,
    parameter logic [NBANKS-1:0] DC_RM_MASK = NBANKS'(3'b110),
    localparam int               BANK_W     = clog2_min1(NBANKS),
    localparam int               TAP_W      = clog2_min1(TAPS),
    localparam int               ACC_W      = acc_width(DATA_W, COEF_W, TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_W-1:0]        sample_in,
    input  logic [BANK_W-1:0]        bank_sel,
    input  logic                     bypass,
    input  logic                     flush,
    input  logic                     coef_we,
    input  logic [BANK_W-1:0]        coef_bank,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_din,
    output logic [DATA_W-1:0]        result,
    output logic                     done,
    output logic                     busy,
    output logic                     overrun,
    output logic                     coef_err
);

    localparam int                    PROD_W   = DATA_W + 1 + COEF_W;
    localparam int                    IDX_W    = clog2_min1(NBANKS * TAPS);
    localparam logic [TAP_W-1:0]      LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic [TAP_W:0]        TAPS_V   = (TAP_W + 1)'(TAPS);
    localparam logic [BANK_W:0]       NBANKS_V = (BANK_W + 1)'(NBANKS);
    localparam logic signed [DATA_W:0] MID     = (DATA_W + 1)'(1) << (DATA_W - 1);

    fir_state_e               state_q, state_d;
    logic [TAP_W-1:0]         tap_q, tap_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [BANK_W-1:0]        bank_q, bank_d;
    logic                     flush_pend_q, flush_pend_d;
    logic [DATA_W-1:0]        result_q, result_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;
    logic                     coef_err_q, coef_err_d;

    logic signed [COEF_W-1:0] coef_ram [NBANKS * TAPS];
    logic [IDX_W-1:0]         coef_wr_idx;
    logic [IDX_W-1:0]         coef_rd_idx;
    logic signed [COEF_W-1:0] coef_rd;
    logic                     coef_wr_ok;

    logic                     accept;
    logic                     dl_flush;
    logic [DATA_W-1:0]        dl_data;
    logic                     dl_valid;
    logic                     dc_on;
    logic signed [DATA_W:0]   x;
    logic signed [PROD_W-1:0] tap_term;

    assign accept = start && (state_q == ST_IDLE);
    assign dc_on  = DC_RM_MASK[bank_q];

    // A flush seen while busy is parked and released on the cycle that produces done.
    assign dl_flush = ((state_q == ST_IDLE) && flush) ||
                      ((state_q == ST_ROUND) && (flush || flush_pend_q));

    fir_delay_line #(
        .TAPS   (TAPS),
        .DATA_W (DATA_W),
        .TAP_W  (TAP_W)
    ) u_delay_line (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .wr_data  (sample_in),
        .flush    (dl_flush),
        .rd_tap   (tap_q),
        .rd_data  (dl_data),
        .rd_valid (dl_valid)
    );

    // The bank feeding an in-flight computation is write-protected until done.
    always_comb begin
        coef_wr_idx = IDX_W'(coef_bank) * IDX_W'(TAPS) + IDX_W'(coef_addr);
        coef_rd_idx = IDX_W'(bank_q) * IDX_W'(TAPS) + IDX_W'(tap_q);
        coef_rd     = coef_ram[coef_rd_idx];
        coef_wr_ok  = coef_we &&
                      ({1'b0, coef_addr} < TAPS_V) &&
                      ({1'b0, coef_bank} < NBANKS_V) &&
                      !((state_q != ST_IDLE) && (coef_bank == bank_q));
        coef_err_d  = coef_we && !coef_wr_ok;
    end

    always_ff @(posedge clk) begin
        if (coef_wr_ok) begin
            coef_ram[coef_wr_idx] <= coef_din;
        end
    end

    always_comb begin
        x = signed'({1'b0, dl_data});
        if (dc_on) begin
            x = x - MID;
        end
        tap_term = '0;
        if (dl_valid) begin
            tap_term = PROD_W'(x) * PROD_W'(coef_rd);
        end
    end

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        acc_d        = acc_q;
        bank_d       = bank_q;
        flush_pend_d = flush_pend_q;
        result_d     = result_q;
        done_d       = 1'b0;
        overrun_d    = start && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                flush_pend_d = 1'b0;
                if (start) begin
                    bank_d = bank_sel;
                    if (bypass) begin
                        result_d = sample_in;
                        done_d   = 1'b1;
                    end else begin
                        state_d = ST_MAC;
                        tap_d   = '0;
                        acc_d   = '0;
                    end
                end
            end
            ST_MAC: begin
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                acc_d = acc_q + ACC_W'(tap_term);
                if (tap_q == LAST_TAP) begin
                    state_d = ST_ROUND;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            ST_ROUND: begin
                result_d     = DATA_W'(round_clamp(RC_W'(acc_q), FRAC_W, DATA_W, dc_on));
                done_d       = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            acc_q        <= '0;
            bank_q       <= '0;
            flush_pend_q <= 1'b0;
            result_q     <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            coef_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            acc_q        <= acc_d;
            bank_q       <= bank_d;
            flush_pend_q <= flush_pend_d;
            result_q     <= result_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            coef_err_q   <= coef_err_d;
        end
    end

    assign result   = result_q;
    assign done     = done_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign coef_err = coef_err_q;

endmodule

// File: tb/tb_fir_filter_bank.sv
// Directed bench for fir_filter_bank with a 4-tap build: table of single-start
// vectors plus hand sequences for overrun, pending flush, coefficient guard and reset.
module tb_fir_filter_bank;

    localparam int TAPS = 4;

    typedef struct {
        logic        fl;
        logic [1:0]  bank;
        logic        byp;
        logic [15:0] smp;
        logic [15:0] exp_res;
        int          exp_lat;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] sample_in;
    logic [1:0]  bank_sel;
    logic        bypass;
    logic        flush;
    logic        coef_we;
    logic [1:0]  coef_bank;
    logic [1:0]  coef_addr;
    logic [31:0] coef_din;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic        overrun;
    logic        coef_err;

    int num_checks = 0;
    int num_fail   = 0;
    vec_t vecs[$];

    fir_filter_bank #(
        .TAPS       (TAPS),
        .DATA_W     (16),
        .COEF_W     (32),
        .FRAC_W     (31),
        .NBANKS     (3),
        .DC_RM_MASK (3'b010)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sample_in (sample_in),
        .bank_sel  (bank_sel),
        .bypass    (bypass),
        .flush     (flush),
        .coef_we   (coef_we),
        .coef_bank (coef_bank),
        .coef_addr (coef_addr),
        .coef_din  (coef_din),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .overrun   (overrun),
        .coef_err  (coef_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic writeCoef(input logic [1:0] bank, input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_bank = bank;
        coef_addr = addr;
        coef_din  = data;
        @(negedge clk);
        coef_we = 1'b0;
        checkOutput("coef_load_err", 32'(coef_err), 32'd0);
    endtask

    // Leaves the caller at the first negedge after the start edge.
    task automatic pulseStart(input logic fl, input logic [1:0] bank, input logic byp, input logic [15:0] smp);
        @(negedge clk);
        start     = 1'b1;
        flush     = fl;
        bank_sel  = bank;
        bypass    = byp;
        sample_in = smp;
        @(negedge clk);
        start  = 1'b0;
        flush  = 1'b0;
        bypass = 1'b0;
    endtask

    task automatic waitDone(input int from, output int lat);
        lat = from;
        while (done !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int lat;
        pulseStart(v.fl, v.bank, v.byp, v.smp);
        waitDone(1, lat);
        checkOutput($sformatf("vec%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        checkOutput($sformatf("vec%0d_result", idx), 32'(result), 32'(v.exp_res));
        @(negedge clk);
        checkOutput($sformatf("vec%0d_done_pulse", idx), 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        rst       = 1'b1;
        start     = 1'b0;
        sample_in = '0;
        bank_sel  = '0;
        bypass    = 1'b0;
        flush     = 1'b0;
        coef_we   = 1'b0;
        coef_bank = '0;
        coef_addr = '0;
        coef_din  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_coef_err", 32'(coef_err), 32'd0);
        rst = 1'b0;

        writeCoef(2'd0, 2'd0, 32'h4000_0000);
        writeCoef(2'd0, 2'd1, 32'h2000_0000);
        writeCoef(2'd0, 2'd2, 32'h1000_0000);
        writeCoef(2'd0, 2'd3, 32'h1000_0000);
        for (int b = 1; b < 3; b++) begin
            for (int a = 0; a < TAPS; a++) begin
                writeCoef(2'(b), 2'(a), 32'h7FFF_FFFF);
            end
        end

        // Impulse through bank 0
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd1000, 16'd500, 6});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd0,    16'd250, 6});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd0,    16'd125, 6});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd0,    16'd125, 6});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd0,    16'd0,   6});
        // Flush then a lone sample: empty taps contribute nothing
        vecs.push_back('{1'b1, 2'd0, 1'b0, 16'd800,  16'd400, 6});
        // Ramp that wraps the write pointer past slot 3
        vecs.push_back('{1'b1, 2'd0, 1'b0, 16'd100,  16'd50,  6});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd200,  16'd125, 6});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd300,  16'd213, 6});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd400,  16'd313, 6});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd500,  16'd413, 6});
        // Positive saturation on bank 2
        vecs.push_back('{1'b1, 2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 6});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 6});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 6});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 16'hFFFF, 16'hFFFF, 6});
        // Mid-scale removal on bank 1 drives the result below zero
        vecs.push_back('{1'b1, 2'd1, 1'b0, 16'd0,    16'd0,   6});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 16'd0,    16'd0,   6});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 16'd0,    16'd0,   6});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 16'd0,    16'd0,   6});
        // Bypass still stores the sample
        vecs.push_back('{1'b1, 2'd0, 1'b1, 16'h1234, 16'h1234, 1});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 16'd0,    16'd1165, 6});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
        end

        // Overrun: rejected start must leave the computation and history alone
        pulseStart(1'b1, 2'd0, 1'b0, 16'd1000);
        @(negedge clk);
        start     = 1'b1;
        sample_in = 16'd5000;
        @(negedge clk);
        start = 1'b0;
        checkOutput("overrun_pulse", 32'(overrun), 32'd1);
        checkOutput("busy_in_mac", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("overrun_clear", 32'(overrun), 32'd0);
        waitDone(4, lat);
        checkOutput("overrun_latency", 32'(lat), 32'd6);
        checkOutput("overrun_result", 32'(result), 32'd500);
        pulseStart(1'b0, 2'd0, 1'b0, 16'd0);
        waitDone(1, lat);
        checkOutput("overrun_history", 32'(result), 32'd250);

        // Flush while busy is deferred until done
        pulseStart(1'b1, 2'd0, 1'b0, 16'd1000);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        waitDone(2, lat);
        checkOutput("pend_flush_latency", 32'(lat), 32'd6);
        checkOutput("pend_flush_result", 32'(result), 32'd500);
        pulseStart(1'b0, 2'd0, 1'b0, 16'd800);
        waitDone(1, lat);
        checkOutput("pend_flush_history", 32'(result), 32'd400);

        // Coefficient guard on the latched bank
        pulseStart(1'b1, 2'd0, 1'b0, 16'd1000);
        coef_we   = 1'b1;
        coef_bank = 2'd0;
        coef_addr = 2'd0;
        coef_din  = 32'h0000_0000;
        @(negedge clk);
        checkOutput("coef_guard_err", 32'(coef_err), 32'd1);
        coef_bank = 2'd2;
        coef_din  = 32'h2000_0000;
        @(negedge clk);
        coef_we = 1'b0;
        checkOutput("coef_other_bank_err", 32'(coef_err), 32'd0);
        waitDone(3, lat);
        checkOutput("coef_guard_inflight", 32'(result), 32'd500);
        pulseStart(1'b1, 2'd0, 1'b0, 16'd1000);
        waitDone(1, lat);
        checkOutput("coef_guard_bank0_kept", 32'(result), 32'd500);
        pulseStart(1'b1, 2'd2, 1'b0, 16'd1000);
        waitDone(1, lat);
        checkOutput("coef_other_bank_written", 32'(result), 32'd250);

        // Reset mid-MAC aborts the computation and clears history
        pulseStart(1'b0, 2'd0, 1'b0, 16'd3000);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_result", 32'(result), 32'd0);
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (TAPS + 4) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checkOutput("no_done_after_reset", 32'(seen), 32'd0);
        pulseStart(1'b0, 2'd0, 1'b0, 16'd1000);
        waitDone(1, lat);
        checkOutput("post_reset_latency", 32'(lat), 32'd6);
        checkOutput("post_reset_impulse0", 32'(result), 32'd500);
        pulseStart(1'b0, 2'd0, 1'b0, 16'd0);
        waitDone(1, lat);
        checkOutput("post_reset_impulse1", 32'(result), 32'd250);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
